reg_write_arbiter: RTL

//  Shares the single write port of BancoRegistro between two writeback sources:
//  A (ALU result) and B (memory load). Each source has a valid/ready handshake
//  and a one-entry holding register. A round-robin arbiter drains the holding

---
 rtl/reg_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : reg_write_arbiter
//  Purpose : Round-robin merge of two writeback sources (A = ALU, B = load)
//            onto the single registered write port of BancoRegistro, with a
//            one-entry holding register per source and an in-flight hazard
//            check. Optional macro ZERO_REG_LOCK_EN hardwires register 0.
//  Rev     : 1.0  initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int BIT_ADDR = 5,
  parameter int BIT_DATO = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [BIT_ADDR-1:0] a_addr,
  input  logic [BIT_DATO-1:0] a_dat,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [BIT_ADDR-1:0] b_addr,
  input  logic [BIT_DATO-1:0] b_dat,
  output logic [BIT_ADDR-1:0] addrW,
  output logic [BIT_DATO-1:0] datW,
  output logic                RegWrite,
  output logic                last_b,
  input  logic [BIT_ADDR-1:0] chkAddr,
  output logic                chkBusy
);

  logic                ha_v_q, hb_v_q;
  logic [BIT_ADDR-1:0] ha_addr_q, hb_addr_q;
  logic [BIT_DATO-1:0] ha_dat_q, hb_dat_q;
  logic                we_q, last_b_q;
  logic [BIT_ADDR-1:0] addrw_q;
  logic [BIT_DATO-1:0] datw_q;

  logic grant_a, grant_b;
  logic acc_a, acc_b;
  logic load_a, load_b;
  logic chk_ok;

  // last_b_q breaks the tie only when both holds are occupied.
  always_comb begin
    grant_a = ha_v_q & (~hb_v_q | last_b_q);
    grant_b = hb_v_q & (~ha_v_q | ~last_b_q);
  end

  assign a_ready = ~ha_v_q | grant_a;
  assign b_ready = ~hb_v_q | grant_b;
  assign acc_a   = a_valid & a_ready;
  assign acc_b   = b_valid & b_ready;

`ifdef ZERO_REG_LOCK_EN
  // Writes to r0 are handshaken and dropped, so they never reach the port.
  assign load_a = acc_a & (a_addr != '0);
  assign load_b = acc_b & (b_addr != '0);
  assign chk_ok = (chkAddr != '0);
`else
  assign load_a = acc_a;
  assign load_b = acc_b;
  assign chk_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ha_v_q    <= 1'b0;
      hb_v_q    <= 1'b0;
      ha_addr_q <= '0;
      hb_addr_q <= '0;
      ha_dat_q  <= '0;
      hb_dat_q  <= '0;
      we_q      <= 1'b0;
      addrw_q   <= '0;
      datw_q    <= '0;
      last_b_q  <= 1'b1;
    end else begin
      if (load_a) begin
        ha_v_q    <= 1'b1;
        ha_addr_q <= a_addr;
        ha_dat_q  <= a_dat;
      end else if (grant_a) begin
        ha_v_q    <= 1'b0;
      end

      if (load_b) begin
        hb_v_q    <= 1'b1;
        hb_addr_q <= b_addr;
        hb_dat_q  <= b_dat;
      end else if (grant_b) begin
        hb_v_q    <= 1'b0;
      end

      if (grant_a) begin
        we_q     <= 1'b1;
        addrw_q  <= ha_addr_q;
        datw_q   <= ha_dat_q;
        last_b_q <= 1'b0;
      end else if (grant_b) begin
        we_q     <= 1'b1;
        addrw_q  <= hb_addr_q;
        datw_q   <= hb_dat_q;
        last_b_q <= 1'b1;
      end else begin
        we_q     <= 1'b0;
      end
    end
  end

  assign RegWrite = we_q;
  assign addrW    = addrw_q;
  assign datW     = datw_q;
  assign last_b   = last_b_q;

  assign chkBusy = chk_ok & ((ha_v_q & (ha_addr_q == chkAddr)) |
                             (hb_v_q & (hb_addr_q == chkAddr)) |
                             (we_q   & (addrw_q   == chkAddr)));

endmodule
`default_nettype wire
